// File: rtl/fir_pkg.sv
// Shared constants, register map and state types for the FIR coefficient AXI4-Lite slave.
package fir_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] COEF_RST = 16'h2000;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_H0     = 8'h04;
  localparam logic [7:0] REG_H1     = 8'h08;
  localparam logic [7:0] REG_H2     = 8'h0C;
  localparam logic [7:0] REG_H3     = 8'h10;
  localparam logic [7:0] REG_STATUS = 8'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  function automatic logic [31:0] sext_coef(input logic [DATA_W-1:0] c);
    return {{(32-DATA_W){c[DATA_W-1]}}, c};
  endfunction

endpackage

// File: rtl/fir_coef_axil_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the coefficient block (slave).
interface fir_coef_axil_if #(
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/fir_axil_wr_capture.sv
// Latches the AW and W beats of one write in either order and flags the cycle the pair completes.
module fir_axil_wr_capture #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_en,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_strb,
  output logic              pair_done
);

  logic              aw_full_q, aw_full_d;
  logic              w_full_q, w_full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        strb_q, strb_d;
  logic              aw_acc, w_acc;
  logic              unused_wbits;

  // Only the coefficient bytes matter; the upper data lanes are never stored.
  assign unused_wbits = ^{wdata[31:DATA_W], wstrb[3:2]};

  always_comb begin
    awready   = accept_en && !aw_full_q;
    wready    = accept_en && !w_full_q;
    aw_acc    = awvalid && awready;
    w_acc     = wvalid && wready;
    pair_done = accept_en && (aw_full_q || aw_acc) && (w_full_q || w_acc);
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (aw_acc) begin
      aw_full_d = 1'b1;
      addr_d    = awaddr;
    end
    if (w_acc) begin
      w_full_d = 1'b1;
      data_d   = wdata[DATA_W-1:0];
      strb_d   = wstrb[1:0];
    end
    if (pair_done) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign wr_strb = strb_q;

endmodule

// File: rtl/fir_coef_axil.sv
// AXI4-Lite owner of the 4-tap FIR coefficients: shadow registers, atomic commit to live h0..h3.
// Build option FIR_CFG_READBACK_EN: H0..H3 reads return the sign-extended shadow value.
module fir_coef_axil
  import fir_pkg::*;
#(
  parameter int              ADDR_W   = 5,
  parameter int              DATA_W   = fir_pkg::DATA_W,
  parameter logic [DATA_W-1:0] COEF_RST = fir_pkg::COEF_RST
) (
  input  logic              clk,
  input  logic              rst_n,
  fir_coef_axil_if.slave    s,
  output logic [DATA_W-1:0] h0,
  output logic [DATA_W-1:0] h1,
  output logic [DATA_W-1:0] h2,
  output logic [DATA_W-1:0] h3,
  output logic              coef_update
);

  wr_state_t         wr_state_q, wr_state_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] shadow_q [4];
  logic [DATA_W-1:0] shadow_d [4];
  logic [DATA_W-1:0] live_q [4];
  logic [DATA_W-1:0] live_d [4];
  logic [15:0]       count_q, count_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_strb;
  logic              pair_done;
  logic              commit;
  logic              pending;
  logic [31:0]       rd_val;
  logic [1:0]        rd_resp;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] nxt,
                                                    input logic [1:0]        be);
    logic [DATA_W-1:0] res;
    res = cur;
    if (be[0]) res[7:0]  = nxt[7:0];
    if (be[1]) res[15:8] = nxt[15:8];
    return res;
  endfunction

  // Readies stay low until the first clock after reset release.
  fir_axil_wr_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept_en (active_q && (wr_state_q == WR_IDLE)),
    .awaddr    (s.awaddr),
    .awvalid   (s.awvalid),
    .awready   (s.awready),
    .wdata     (s.wdata),
    .wstrb     (s.wstrb),
    .wvalid    (s.wvalid),
    .wready    (s.wready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .pair_done (pair_done)
  );

  always_comb begin
    active_d   = 1'b1;
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    shadow_d   = shadow_q;
    live_d     = live_q;
    count_d    = count_q;
    commit     = 1'b0;
    case (wr_state_q)
      WR_IDLE: if (pair_done) wr_state_d = WR_EXEC;
      WR_EXEC: begin
        wr_state_d = WR_RESP;
        bresp_d    = RESP_OKAY;
        case (wr_addr)
          ADDR_W'(REG_CTRL): commit      = wr_strb[0] && wr_data[0];
          ADDR_W'(REG_H0):   shadow_d[0] = merge_bytes(shadow_q[0], wr_data, wr_strb);
          ADDR_W'(REG_H1):   shadow_d[1] = merge_bytes(shadow_q[1], wr_data, wr_strb);
          ADDR_W'(REG_H2):   shadow_d[2] = merge_bytes(shadow_q[2], wr_data, wr_strb);
          ADDR_W'(REG_H3):   shadow_d[3] = merge_bytes(shadow_q[3], wr_data, wr_strb);
          default:           bresp_d     = RESP_SLVERR;
        endcase
        if (commit) begin
          live_d  = shadow_q;
          count_d = count_q + 16'd1;
        end
      end
      WR_RESP: if (s.bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign pending = (shadow_q[0] != live_q[0]) || (shadow_q[1] != live_q[1]) ||
                   (shadow_q[2] != live_q[2]) || (shadow_q[3] != live_q[3]);

  // Read decode works on registered state, so a read racing WR_EXEC sees the old contents.
  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (s.araddr)
      ADDR_W'(REG_CTRL):   rd_val = '0;
`ifdef FIR_CFG_READBACK_EN
      ADDR_W'(REG_H0):     rd_val = sext_coef(shadow_q[0]);
      ADDR_W'(REG_H1):     rd_val = sext_coef(shadow_q[1]);
      ADDR_W'(REG_H2):     rd_val = sext_coef(shadow_q[2]);
      ADDR_W'(REG_H3):     rd_val = sext_coef(shadow_q[3]);
`else
      ADDR_W'(REG_H0), ADDR_W'(REG_H1),
      ADDR_W'(REG_H2), ADDR_W'(REG_H3): rd_val = '0;
`endif
      ADDR_W'(REG_STATUS): rd_val = {15'd0, pending, count_q};
      default:             rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: if (s.arvalid && s.arready) begin
        rd_state_d = RD_DATA;
        rdata_d    = rd_val;
        rresp_d    = rd_resp;
      end
      RD_DATA: if (s.rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      active_q   <= 1'b0;
      count_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= COEF_RST;
        live_q[i]   <= COEF_RST;
      end
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      active_q   <= active_d;
      count_q    <= count_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      shadow_q   <= shadow_d;
      live_q     <= live_d;
    end
  end

  assign s.bvalid   = (wr_state_q == WR_RESP);
  assign s.bresp    = bresp_q;
  assign s.arready  = active_q && (rd_state_q == RD_IDLE);
  assign s.rvalid   = (rd_state_q == RD_DATA);
  assign s.rdata    = rdata_q;
  assign s.rresp    = rresp_q;
  assign h0          = live_q[0];
  assign h1          = live_q[1];
  assign h2          = live_q[2];
  assign h3          = live_q[3];
  assign coef_update = commit;

endmodule

// File: tb/tb_fir_coef_axil.sv
// Scoreboard bench for fir_coef_axil: randomized AXI-Lite traffic against a register-map model.
module tb_fir_coef_axil;

  localparam int LIMIT = 50;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef FIR_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_coef_axil_if #(.ADDR_W(5)) bus ();
  logic [15:0] h0, h1, h2, h3;
  logic        coef_update;

  fir_coef_axil dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (bus),
    .h0          (h0),
    .h1          (h1),
    .h2          (h2),
    .h3          (h3),
    .coef_update (coef_update)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  logic [15:0] m_shadow [4];
  logic [15:0] m_live [4];
  logic [15:0] m_prev [4];
  logic [15:0] m_count;
  int m_commits = 0;
  int seen_pulses = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (bound expired or unexpected event)", name);
  endtask

  function automatic logic [15:0] get_h(input int i);
    case (i)
      0: return h0;
      1: return h1;
      2: return h2;
      default: return h3;
    endcase
  endfunction

  // Reference model: the register map as plain arrays and a counter.
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 16'h2000;
      m_live[i]   = 16'h2000;
      m_prev[i]   = 16'h2000;
    end
    m_count = 16'd0;
  endfunction

  function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    case (a)
      5'h00: begin
        if (be[0] && d[0]) begin
          m_prev = m_live;
          m_live = m_shadow;
          m_count = m_count + 16'd1;
          m_commits++;
        end
        return OKAY;
      end
      5'h04, 5'h08, 5'h0C, 5'h10: begin
        idx = int'(a) / 4 - 1;
        if (be[0]) m_shadow[idx][7:0]  = d[7:0];
        if (be[1]) m_shadow[idx][15:8] = d[15:8];
        return OKAY;
      end
      default: return SLVERR;
    endcase
  endfunction

  function automatic logic [33:0] model_read(input logic [4:0] a);
    bit pend;
    pend = 1'b0;
    for (int i = 0; i < 4; i++) if (m_shadow[i] != m_live[i]) pend = 1'b1;
    case (a)
      5'h00: return {OKAY, 32'd0};
      5'h04, 5'h08, 5'h0C, 5'h10:
        return {OKAY, READBACK ? {{16{m_shadow[int'(a)/4-1][15]}}, m_shadow[int'(a)/4-1]} : 32'd0};
      5'h14: return {OKAY, 15'd0, pend, m_count};
      default: return {SLVERR, 32'd0};
    endcase
  endfunction

  task automatic check_h();
    for (int i = 0; i < 4; i++)
      check_output($sformatf("h%0d", i), 32'(get_h(i)), 32'(m_live[i]));
  endtask

  task automatic drive_aw(input logic [4:0] a, input int dly);
    int n;
    repeat (dly) @(negedge clk);
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) report_fail("aw_accept");
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] be, input int dly);
    int n;
    repeat (dly) @(negedge clk);
    bus.wdata  = d;
    bus.wstrb  = be;
    bus.wvalid = 1'b1;
    n = 0;
    while (!bus.wready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) report_fail("w_accept");
    @(posedge clk);
    @(negedge clk);
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp_resp, input int dly);
    int n;
    n = 0;
    while (!bus.bvalid && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) begin
      report_fail("bvalid_wait");
      void'(exp_b_q.pop_back());
      return;
    end
    repeat (dly) begin
      @(negedge clk);
      check_output("bvalid_hold", 32'(bus.bvalid), 32'd1);
      check_output("bresp_hold", 32'(bus.bresp), 32'(exp_resp));
    end
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic apply_stimulus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                                      input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] er;
    er = model_write(a, d, be);
    exp_b_q.push_back(er);
    fork
      drive_aw(a, aw_dly);
      drive_w(d, be, w_dly);
    join
    wait_b(er, b_dly);
    check_h();
  endtask

  task automatic drive_read(input logic [4:0] a, input int ar_dly, input int r_dly);
    int n;
    repeat (ar_dly) @(negedge clk);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) report_fail("ar_accept");
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) begin
      report_fail("rvalid_wait");
      void'(exp_r_q.pop_back());
      return;
    end
    repeat (r_dly) @(negedge clk);
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic apply_stimulus_read(input logic [4:0] a, input int ar_dly, input int r_dly);
    exp_r_q.push_back(model_read(a));
    drive_read(a, ar_dly, r_dly);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks commit timing against the model.
  initial begin : monitor
    logic        pulse_prev;
    logic [33:0] er;
    pulse_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.bvalid && bus.bready) begin
        if (exp_b_q.size() == 0) report_fail("b_unexpected");
        else check_output("bresp", 32'(bus.bresp), 32'(exp_b_q.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r_q.size() == 0) report_fail("r_unexpected");
        else begin
          er = exp_r_q.pop_front();
          check_output("rresp", 32'(bus.rresp), 32'(er[33:32]));
          check_output("rdata", bus.rdata, er[31:0]);
        end
      end
      if (pulse_prev)
        for (int i = 0; i < 4; i++)
          check_output($sformatf("h%0d_after_update", i), 32'(get_h(i)), 32'(m_live[i]));
      if (coef_update) begin
        seen_pulses++;
        for (int i = 0; i < 4; i++)
          check_output($sformatf("h%0d_at_update", i), 32'(get_h(i)), 32'(m_prev[i]));
      end
      pulse_prev = coef_update;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [4:0]  addrs [8];
    logic [4:0]  a;
    logic [31:0] d;
    addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check_output("rst_awready", 32'(bus.awready), 32'd0);
    check_output("rst_wready", 32'(bus.wready), 32'd0);
    check_output("rst_arready", 32'(bus.arready), 32'd0);
    check_output("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check_output("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_output("rst_bresp", 32'(bus.bresp), 32'd0);
    check_output("rst_rresp", 32'(bus.rresp), 32'd0);
    check_output("rst_rdata", bus.rdata, 32'd0);
    check_output("rst_coef_update", 32'(coef_update), 32'd0);
    check_h();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset release and status");
    apply_stimulus_read(5'h14, 0, 0);

    $display("[TB] shadow write then commit");
    apply_stimulus_write(5'h08, 32'h0000_4000, 4'b0011, 0, 0, 0);
    apply_stimulus_read(5'h14, 0, 0);
    apply_stimulus_write(5'h00, 32'h0000_0001, 4'b0001, 0, 0, 0);
    apply_stimulus_read(5'h14, 0, 0);

    $display("[TB] AW ahead of W, slow bready");
    apply_stimulus_write(5'h10, 32'h0000_1234, 4'b0011, 0, 3, 5);
    apply_stimulus_read(5'h10, 0, 0);
    apply_stimulus_read(5'h14, 0, 2);

    $display("[TB] error responses");
    apply_stimulus_write(5'h18, 32'h0000_5555, 4'b1111, 0, 0, 0);
    apply_stimulus_write(5'h14, 32'hFFFF_FFFF, 4'b1111, 1, 0, 0);
    apply_stimulus_read(5'h1C, 0, 0);
    apply_stimulus_read(5'h14, 0, 0);

    $display("[TB] partial strobe");
    apply_stimulus_write(5'h0C, 32'hFFFF_ABCD, 4'b0001, 1, 0, 0);
    apply_stimulus_read(5'h0C, 0, 0);

    $display("[TB] read racing a commit");
    exp_r_q.push_back(model_read(5'h14));
    fork
      drive_read(5'h14, 1, 0);
      apply_stimulus_write(5'h00, 32'h0000_0001, 4'b0001, 0, 0, 0);
    join
    apply_stimulus_read(5'h14, 0, 0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : addrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 2) == 0) begin
        apply_stimulus_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
      end else begin
        d = $urandom;
        apply_stimulus_write(a, d, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    apply_stimulus_read(5'h14, 0, 0);

    $display("[TB] reset mid-flight");
    bus.araddr  = 5'h14;
    bus.arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.awaddr  = 5'h00;
    bus.wdata   = 32'h0000_0001;
    bus.wstrb   = 4'b1111;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("midrst_bvalid", 32'(bus.bvalid), 32'd0);
    check_output("midrst_rvalid", 32'(bus.rvalid), 32'd0);
    check_output("midrst_coef_update", 32'(coef_update), 32'd0);
    check_h();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus_read(5'h14, 0, 0);
    apply_stimulus_read(5'h0C, 0, 0);

    repeat (3) @(negedge clk);
    check_output("update_pulses", 32'(seen_pulses), 32'(m_commits));
    check_output("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
    check_output("r_queue_empty", 32'(exp_r_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
